// File: rtl/bcd_serial_adder.sv
// Digit-serial packed-BCD adder: one shared digit slice, LSD first, start/busy/done handshake.
// Optional ten's-complement subtract is enabled by defining BCD_SUB_EN.
module bcd_serial_adder #(
  parameter int unsigned DIGITS = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  sub,
  input  logic                  cin,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   sum,
  output logic                  cout,
  output logic                  err
);

  localparam int unsigned W     = 4 * DIGITS;
  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic [W-1:0]       a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic [DIGITS-1:0]  inv_q, inv_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               carry_q, carry_d;
  logic               busy_q, busy_d, done_q, done_d;
  logic               cout_q, cout_d, err_q, err_d;

  logic               sub_eff;
  logic [3:0]         dig_a, dig_b, dig_s;
  logic [4:0]         raw;
  logic               carry_nx, dig_inv;

`ifdef BCD_SUB_EN
  assign sub_eff = sub;
`else
  logic unused_sub;
  assign unused_sub = sub;
  assign sub_eff    = 1'b0;
`endif

  // Shared digit slice: select digit idx, add, decimal-correct
  always_comb begin
    dig_a   = 4'd0;
    dig_b   = 4'd0;
    dig_inv = 1'b0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        dig_a   = a_q[4*i +: 4];
        dig_b   = b_q[4*i +: 4];
        dig_inv = inv_q[i];
      end
    end
    raw = 5'(dig_a) + 5'(dig_b) + 5'(carry_q);
    if (raw > 5'd9) begin
      dig_s    = 4'(raw + 5'd6);
      carry_nx = 1'b1;
    end else begin
      dig_s    = raw[3:0];
      carry_nx = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    inv_d   = inv_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    err_d   = err_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d = a;
          // Invalid-digit mask is taken from the original operands, before complementing B
          for (int unsigned i = 0; i < DIGITS; i++) begin
            inv_d[i]       = (a[4*i +: 4] > 4'd9) || (b[4*i +: 4] > 4'd9);
            b_d[4*i +: 4]  = sub_eff ? 4'(4'd9 - b[4*i +: 4]) : b[4*i +: 4];
          end
          idx_d   = '0;
          carry_d = sub_eff ? 1'b1 : cin;
          err_d   = 1'b0;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        for (int unsigned i = 0; i < DIGITS; i++) begin
          if (idx_q == IDX_W'(i)) sum_d[4*i +: 4] = dig_s;
        end
        carry_d = carry_nx;
        idx_d   = idx_q + IDX_W'(1);
        if (dig_inv) err_d = 1'b1;
        if (idx_q == IDX_W'(DIGITS - 1)) begin
          cout_d  = carry_nx;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      inv_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      inv_q   <= inv_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
  assign err  = err_q;

endmodule

// File: tb/tb_bcd_serial_adder.sv
// Random and directed stimulus for bcd_serial_adder, checked every cycle against a
// transaction-level decimal model; honours BCD_SUB_EN the same way as the design.
module tb_bcd_serial_adder;

  localparam int unsigned DIGITS = 4;
  localparam int unsigned W      = 4 * DIGITS;
`ifdef BCD_SUB_EN
  localparam bit SUB_EN = 1'b1;
`else
  localparam bit SUB_EN = 1'b0;
`endif

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic         sub   = 1'b0;
  logic         cin   = 1'b0;
  logic [W-1:0] a     = '0;
  logic [W-1:0] b     = '0;
  logic         busy, done, cout, err;
  logic [W-1:0] sum;

  int vectors     = 0;
  int miscompares = 0;
  int done_pulses = 0;

  bcd_serial_adder #(.DIGITS(DIGITS)) dut (
    .clock(clock), .reset(reset), .start(start), .sub(sub), .cin(cin),
    .a(a), .b(b), .busy(busy), .done(done), .sum(sum), .cout(cout), .err(err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Digit-by-digit decimal addition straight from the arithmetic rules
  function automatic void model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                input logic mcin, input logic msub,
                                output logic [W-1:0] s, output logic co, output logic er);
    int c, da, db, raw;
    bit sub_on;
    sub_on = msub && SUB_EN;
    c  = sub_on ? 1 : int'(mcin);
    er = 1'b0;
    s  = '0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      da = int'(ma[4*i +: 4]);
      db = int'(mb[4*i +: 4]);
      if (da > 9 || db > 9) er = 1'b1;
      if (sub_on) db = (9 - db) & 15;
      raw = da + db + c;
      if (raw > 9) begin s[4*i +: 4] = 4'((raw + 6) % 16); c = 1; end
      else         begin s[4*i +: 4] = 4'(raw);            c = 0; end
    end
    co = (c == 1);
  endfunction

  function automatic int bcd2int(input logic [W-1:0] v);
    int r = 0;
    for (int i = int'(DIGITS) - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [W-1:0] int2bcd(input int v);
    logic [W-1:0] r = '0;
    int t = v;
    for (int i = 0; i < int'(DIGITS); i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  // Transaction-level expectation: result appears DIGITS edges after the accepted start
  logic [W-1:0] m_sum = '0, p_sum;
  logic m_busy = 0, m_done = 0, m_cout = 0, m_err = 0, p_cout, p_err;
  int m_left = 0, m_phase = 0;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_sum = '0; m_busy = 0; m_done = 0; m_cout = 0; m_err = 0; m_phase = 0; m_left = 0;
    end else begin
      case (m_phase)
        0: if (start) begin
             model(a, b, cin, sub, p_sum, p_cout, p_err);
             m_left = int'(DIGITS); m_phase = 1; m_busy = 1; m_err = 0;
           end
        1: begin
             m_left--;
             if (m_left == 0) begin
               m_phase = 2; m_busy = 0; m_done = 1;
               m_sum = p_sum; m_cout = p_cout; m_err = p_err;
             end
           end
        default: begin m_done = 0; m_phase = 0; end
      endcase
    end
  end

  always @(negedge clock) begin
    if (!reset) begin
      chk("busy", W'(busy), W'(m_busy));
      chk("done", W'(done), W'(m_done));
      if (done) done_pulses++;
      if (!m_busy) begin
        chk("sum",  sum,     m_sum);
        chk("cout", W'(cout), W'(m_cout));
        chk("err",  W'(err),  W'(m_err));
      end
    end
  end

  // One operation; optional re-starts during RUN and in the DONE cycle
  task automatic op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tcin,
                    input logic tsub, input bit disturb,
                    output logic [W-1:0] rs, output logic rco, output logic rer);
    bit seen = 0;
    @(negedge clock);
    a = ta; b = tb_v; cin = tcin; sub = tsub; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    if (disturb) begin a = ~ta; b = 16'h1111; cin = ~tcin; start = 1'b1; end
    for (int n = 0; n < int'(DIGITS) + 4 && !seen; n++) begin
      @(negedge clock);
      start = 1'b0;
      if (done) begin
        seen = 1;
        rs = sum; rco = cout; rer = err;
        if (disturb) begin
          start = 1'b1;
          @(negedge clock);
          start = 1'b0;
        end
      end
    end
    if (!seen) begin
      rs = 'x; rco = 1'bx; rer = 1'bx;
      vectors++; miscompares++;
      $display("FAIL done_timeout: got no done expected done within %0d cycles", DIGITS + 4);
    end
  endtask

  logic [W-1:0] rs, ms, ra, rb;
  logic rco, rer, mco, mer, rcin, rsub;
  int pulses0, ia, ib, ie;

  initial begin
    // Model pins
    model(16'h1234, 16'h5678, 1'b0, 1'b0, ms, mco, mer);
    chk("pin_add", ms, 16'h6912);
    model(16'h9999, 16'h0001, 1'b0, 1'b0, ms, mco, mer);
    chk("pin_ripple", {ms[W-2:0], mco}, {15'h0000, 1'b1});
    model(16'h00A0, 16'h0001, 1'b0, 1'b0, ms, mco, mer);
    chk("pin_inv", {ms[W-2:0], mer}, {15'h0101, 1'b1});

    repeat (3) @(posedge clock);
    #1;
    chk("rst_busy", W'(busy), '0);
    chk("rst_sum",  sum, '0);
    chk("rst_done", W'(done), '0);
    @(posedge clock); #2 reset = 1'b0;

    pulses0 = done_pulses;
    op(16'h1234, 16'h5678, 1'b0, 1'b0, 1'b0, rs, rco, rer);
    chk("basic_sum", rs, 16'h6912);
    chk("basic_cout_err", {14'h0, rco, rer}, 16'h0000);
    op(16'h9999, 16'h0001, 1'b0, 1'b0, 1'b0, rs, rco, rer);
    chk("ripple_sum", rs, 16'h0000);
    chk("ripple_cout", W'(rco), W'(1'b1));
    op(16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, rs, rco, rer);
    chk("cin_sum", rs, 16'h0001);
    chk("cin_cout", W'(rco), '0);
    op(16'h00A0, 16'h0001, 1'b0, 1'b0, 1'b0, rs, rco, rer);
    chk("inv_sum", rs, 16'h0101);
    @(negedge clock);
    chk("inv_err_held", W'(err), W'(1'b1));
    op(16'h0002, 16'h0003, 1'b0, 1'b0, 1'b0, rs, rco, rer);
    chk("err_cleared", {rs[W-2:0], rer}, {15'h0005, 1'b0});

    @(negedge clock);
    pulses0 = done_pulses;
    op(16'h4321, 16'h1234, 1'b0, 1'b0, 1'b1, rs, rco, rer);
    chk("busy_ign_sum", rs, 16'h5555);
    @(negedge clock); @(negedge clock);
    chk("busy_ign_pulses", W'(done_pulses - pulses0), W'(1));
    chk("busy_ign_idle", W'(busy), '0);

    // Reset in the middle of an operation
    @(negedge clock);
    a = 16'h7777; b = 16'h2222; cin = 1'b0; sub = 1'b0; start = 1'b1;
    @(negedge clock); start = 1'b0;
    pulses0 = done_pulses;
    @(posedge clock); @(posedge clock); #2 reset = 1'b1;
    #1;
    chk("mid_rst_out", {sum[W-5:0], busy, done, cout, err}, '0);
    chk("mid_rst_sum", sum, '0);
    @(posedge clock); #2 reset = 1'b0;
    repeat (DIGITS + 3) @(negedge clock);
    chk("mid_rst_no_done", W'(done_pulses - pulses0), '0);
    op(16'h0005, 16'h0005, 1'b0, 1'b0, 1'b0, rs, rco, rer);
    chk("post_rst_sum", {rs[W-2:0], rco}, {15'h0010, 1'b0});

    op(16'h0500, 16'h0123, 1'b0, 1'b1, 1'b0, rs, rco, rer);
    chk("sub_ab", {rs[W-2:0], rco}, SUB_EN ? {15'h0377, 1'b1} : {15'h0623, 1'b0});
    op(16'h0123, 16'h0500, 1'b0, 1'b1, 1'b0, rs, rco, rer);
    chk("sub_ba", {rs[W-2:0], rco}, SUB_EN ? {15'h1623, 1'b0} : {15'h0623, 1'b0});
    chk("sub_ba_msd", W'(rs[W-1:W-4]), SUB_EN ? W'(9) : W'(0));

    // Randomized operations, cross-checked against integer decimal arithmetic when valid
    for (int k = 0; k < 150; k++) begin
      for (int d = 0; d < int'(DIGITS); d++) begin
        ra[4*d +: 4] = ($urandom_range(0, 15) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
        rb[4*d +: 4] = ($urandom_range(0, 15) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
      end
      rcin = 1'($urandom_range(0, 1));
      rsub = 1'($urandom_range(0, 1));
      op(ra, rb, rcin, rsub, ($urandom_range(0, 7) == 0), rs, rco, rer);
      model(ra, rb, rcin, rsub, ms, mco, mer);
      if (!mer) begin
        ia = bcd2int(ra); ib = bcd2int(rb);
        if (rsub && SUB_EN) begin
          ie = ia - ib + 10000;
          chk("rnd_sub_int", {rs[W-2:0], rco}, {int2bcd(ie % 10000)} << 1 | W'(ia >= ib));
        end else begin
          ie = ia + ib + int'(rcin);
          chk("rnd_add_int", {rs[W-2:0], rco}, {int2bcd(ie % 10000)} << 1 | W'(ie >= 10000));
        end
        chk("rnd_int_msd", W'(rs[W-1]), W'(int2bcd(((rsub && SUB_EN) ? ia - ib + 10000 : ie) % 10000) >> (W - 1)));
      end
      repeat ($urandom_range(0, 2)) @(negedge clock);
    end

    repeat (3) @(negedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
